// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory request at a
// time, and registers each returned instruction (with commit-trace fields) into the
// fetch->decode register. Handles execute redirects and the hazard-unit stall.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fetch_stall              hold outputs, issue no new request
//   redirect_valid/_pc       flush and restart fetch at redirect_pc (bits [1:0] ignored)
//   imem_req_valid/_ready    request handshake; imem_req_addr carries the PC
//   imem_resp_valid/_data    single-cycle response pulse with the instruction
//   fetch_o_*                registered fetch->decode payload and commit trace
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [63:0] fetch_o_pc,
  output logic [31:0] fetch_o_instr,
  output logic        fetch_o_commit,
  output logic [63:0] fetch_o_commit_pc,
  output logic [31:0] fetch_o_commit_instr,
  output logic [63:0] fetch_o_commit_pre_pc
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   last_pc;
  logic              drop;
  logic [ILEN-1:0]   hold_data;

  logic              handshake;
  logic              deliver;
  logic [ILEN-1:0]   deliver_data;
  logic [XLEN-1:0]   redirect_target;
  logic              redirect_pc_unused;

  // Request is combinational from state so a stall withdraws it in the same cycle.
  assign imem_req_valid = !rst && (state == REQ) && !fetch_stall;
  assign imem_req_addr  = pc;
  assign handshake      = imem_req_valid && imem_req_ready;

  assign redirect_target    = {redirect_pc[XLEN-1:2], 2'b00};
  assign redirect_pc_unused = ^redirect_pc[1:0];

  // Deliver either a fresh (non-dropped) response or the instruction buffered in HOLD.
  assign deliver = !fetch_stall &&
                   (((state == WAIT) && imem_resp_valid && !drop) || (state == HOLD));
  assign deliver_data = (state == HOLD) ? hold_data : imem_resp_data;

  // Single-process FSM with registered payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= REQ;
      pc                    <= RESET_PC;
      drop                  <= 1'b0;
      last_pc               <= '0;
      hold_data             <= '0;
      fetch_o_pc            <= '0;
      fetch_o_instr         <= '0;
      fetch_o_commit        <= 1'b0;
      fetch_o_commit_pc     <= '0;
      fetch_o_commit_instr  <= '0;
      fetch_o_commit_pre_pc <= '0;
    end else if (redirect_valid) begin
      // Redirect overrides stall and any delivery; last_pc is kept.
      pc                    <= redirect_target;
      fetch_o_pc            <= '0;
      fetch_o_instr         <= '0;
      fetch_o_commit        <= 1'b0;
      fetch_o_commit_pc     <= '0;
      fetch_o_commit_instr  <= '0;
      fetch_o_commit_pre_pc <= '0;
      case (state)
        REQ: begin
          // A request accepted this cycle is stale: its response must be dropped.
          drop  <= handshake;
          state <= handshake ? WAIT : REQ;
        end
        WAIT: begin
          if (imem_resp_valid) begin
            drop  <= 1'b0;
            state <= REQ;
          end else begin
            drop  <= 1'b1;
            state <= WAIT;
          end
        end
        default: begin
          drop  <= 1'b0;
          state <= REQ;
        end
      endcase
    end else begin
      if (deliver) begin
        fetch_o_pc            <= pc;
        fetch_o_instr         <= deliver_data;
        fetch_o_commit        <= 1'b1;
        fetch_o_commit_pc     <= pc;
        fetch_o_commit_instr  <= deliver_data;
        fetch_o_commit_pre_pc <= last_pc;
        last_pc               <= pc;
        pc                    <= pc + XLEN'(4);
      end else if (!fetch_stall) begin
        fetch_o_pc            <= '0;
        fetch_o_instr         <= '0;
        fetch_o_commit        <= 1'b0;
        fetch_o_commit_pc     <= '0;
        fetch_o_commit_instr  <= '0;
        fetch_o_commit_pre_pc <= '0;
      end

      case (state)
        REQ: begin
          if (handshake) state <= WAIT;
        end
        WAIT: begin
          if (imem_resp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= REQ;
            end else if (fetch_stall) begin
              hold_data <= imem_resp_data;
              state     <= HOLD;
            end else begin
              state <= REQ;
            end
          end
        end
        HOLD: begin
          if (!fetch_stall) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the memory side is driven by hand, cycle by cycle,
// and every observed output is compared against hand-computed values.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [63:0] fetch_o_pc;
  logic [31:0] fetch_o_instr;
  logic        fetch_o_commit;
  logic [63:0] fetch_o_commit_pc;
  logic [31:0] fetch_o_commit_instr;
  logic [63:0] fetch_o_commit_pre_pc;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk                   (clk),
    .rst                   (rst),
    .fetch_stall           (fetch_stall),
    .redirect_valid        (redirect_valid),
    .redirect_pc           (redirect_pc),
    .imem_req_valid        (imem_req_valid),
    .imem_req_ready        (imem_req_ready),
    .imem_req_addr         (imem_req_addr),
    .imem_resp_valid       (imem_resp_valid),
    .imem_resp_data        (imem_resp_data),
    .fetch_o_pc            (fetch_o_pc),
    .fetch_o_instr         (fetch_o_instr),
    .fetch_o_commit        (fetch_o_commit),
    .fetch_o_commit_pc     (fetch_o_commit_pc),
    .fetch_o_commit_instr  (fetch_o_commit_instr),
    .fetch_o_commit_pre_pc (fetch_o_commit_pre_pc)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
  endtask

  task automatic chk_out(input string tag, input logic commit, input logic [63:0] pc,
                         input logic [31:0] instr, input logic [63:0] pre_pc);
    chk({tag, ".commit"},       64'(fetch_o_commit), 64'(commit));
    chk({tag, ".pc"},           fetch_o_pc, pc);
    chk({tag, ".instr"},        64'(fetch_o_instr), 64'(instr));
    chk({tag, ".commit_pc"},    fetch_o_commit_pc, pc);
    chk({tag, ".commit_instr"}, 64'(fetch_o_commit_instr), 64'(instr));
    chk({tag, ".pre_pc"},       fetch_o_commit_pre_pc, pre_pc);
  endtask

  task automatic chk_req(input string tag, input logic valid, input logic [63:0] addr);
    chk({tag, ".req_valid"}, 64'(imem_req_valid), 64'(valid));
    if (valid) chk({tag, ".req_addr"}, imem_req_addr, addr);
  endtask

  initial begin
    rst             = 1'b1;
    fetch_stall     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;

    // Reset state
    tick();
    tick();
    chk_out("reset", 1'b0, 64'h0, 32'h0, 64'h0);
    chk_req("reset", 1'b0, 64'h0);

    // 1: first two deliveries with a one-cycle memory
    rst = 1'b0;
    #1;
    chk_req("t1_req0", 1'b1, 64'h8000_0000);
    tick();                                   // accepted -> WAIT
    chk_req("t1_wait0", 1'b0, 64'h0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0013;
    tick();                                   // delivered
    imem_resp_valid = 1'b0;
    chk_out("t1_d0", 1'b1, 64'h8000_0000, 32'h0000_0013, 64'h0);
    chk_req("t1_req1", 1'b1, 64'h8000_0004);
    tick();                                   // accepted, bubble
    chk_out("t1_bubble", 1'b0, 64'h0, 32'h0, 64'h0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0010_0093;
    tick();
    imem_resp_valid = 1'b0;
    chk_out("t1_d1", 1'b1, 64'h8000_0004, 32'h0010_0093, 64'h8000_0000);
    chk_req("t1_req2", 1'b1, 64'h8000_0008);

    // 2: redirect while WAIT, stale response dropped
    tick();                                   // 0x80000008 accepted -> WAIT
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1002;
    tick();
    redirect_valid = 1'b0;
    chk_out("t2_redir", 1'b0, 64'h0, 32'h0, 64'h0);
    chk_req("t2_wait", 1'b0, 64'h0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    chk_out("t2_stale", 1'b0, 64'h0, 32'h0, 64'h0);
    chk_req("t2_req", 1'b1, 64'h8000_1000);

    // 3: stall holding a delivered instruction, then a response under stall
    tick();                                   // 0x80001000 accepted
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0020_0113;
    tick();
    imem_resp_valid = 1'b0;
    chk_out("t3_dA", 1'b1, 64'h8000_1000, 32'h0020_0113, 64'h8000_0004);
    fetch_stall = 1'b1;
    #1;
    chk_req("t3_stall_req", 1'b0, 64'h0);
    tick();
    tick();
    chk_out("t3_holdA", 1'b1, 64'h8000_1000, 32'h0020_0113, 64'h8000_0004);
    fetch_stall = 1'b0;
    #1;
    chk_req("t3_req", 1'b1, 64'h8000_1004);
    tick();                                   // accepted, bubble
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0030_0193;
    fetch_stall     = 1'b1;
    tick();                                   // stall cycle 1: buffered -> HOLD
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    chk_out("t3_s1", 1'b0, 64'h0, 32'h0, 64'h0);
    chk_req("t3_s1", 1'b0, 64'h0);
    tick();                                   // stall cycle 2
    chk_out("t3_s2", 1'b0, 64'h0, 32'h0, 64'h0);
    tick();                                   // stall cycle 3
    chk_out("t3_s3", 1'b0, 64'h0, 32'h0, 64'h0);
    chk_req("t3_s3", 1'b0, 64'h0);
    fetch_stall = 1'b0;
    tick();                                   // release -> deliver buffer
    chk_out("t3_dB", 1'b1, 64'h8000_1004, 32'h0030_0193, 64'h8000_1000);
    chk_req("t3_next", 1'b1, 64'h8000_1008);

    // 4: ready low for 5 cycles
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_req("t4_nr", 1'b1, 64'h8000_1008);
      chk("t4_nr.commit", 64'(fetch_o_commit), 64'h0);
    end
    imem_req_ready = 1'b1;
    tick();                                   // accepted -> WAIT

    // 5: redirect and response in the same WAIT cycle
    redirect_valid  = 1'b1;
    redirect_pc     = 64'hFFFF_FFFF_FFFF_FFFC;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    tick();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    chk_out("t5_redir", 1'b0, 64'h0, 32'h0, 64'h0);
    chk_req("t5_req", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);

    // 6: delivery at the top of the address space wraps the PC to 0
    tick();                                   // accepted
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0040_0213;
    tick();
    imem_resp_valid = 1'b0;
    chk_out("t6_dC", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0040_0213, 64'h8000_1004);
    chk_req("t6_wrap", 1'b1, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
